// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter.
//  arb_state_e : arbiter FSM states
//  MASK_WORD   : byte enables for a full-word access (used for fetches)
//  mem_cmd_t   : one memory command as presented on the mem_* port
//  fetch_cmd() : builds the fixed-form fetch command from an address
package mem_arb_pkg;

    // Command field widths; the arbiter's ADDRESS/DATA parameters default to these.
    localparam int unsigned CMD_ADDR_W = 32;
    localparam int unsigned CMD_DATA_W = 32;

    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_DM   = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [3:0]            mask;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Fetches are always full-word reads with zero write data.
    function automatic mem_cmd_t fetch_cmd(input logic [CMD_ADDR_W-1:0] addr);
        mem_cmd_t cmd;
        cmd.we    = 1'b0;
        cmd.mask  = MASK_WORD;
        cmd.addr  = addr;
        cmd.wdata = '0;
        return cmd;
    endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Loadable down-counter used as the transaction watchdog of mem_port_arbiter.
//  clk        : clock, rising edge
//  rst        : synchronous active-low reset (count cleared)
//  load       : load load_value into the counter
//  load_value : cycles-minus-one to count before expiring
//  enable     : count while high (arbiter busy)
//  expire     : high in the cycle the enabled counter sits at zero
module mem_arb_watchdog #(
    parameter int unsigned WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             expire
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = enable && !load && (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and the LSU (DM).
// Data requests win, except that after MAX_DM_BURST consecutive DM grants made while a fetch
// waited, the fetch is served next. The granted command is registered onto mem_* and held
// until mem_valid; the read data and a one-cycle valid pulse are then registered to the winner.
// Optional feature macro: ARB_TIMEOUT_EN adds a watchdog and the err output.
//  clk, rst                         : clock; synchronous active-low reset
//  if_req/if_addr                   : fetch request (held until if_valid)
//  if_rdata/if_valid                : fetch response
//  dm_req/we/mask/addr/wdata        : load/store request (held until dm_valid)
//  dm_rdata/dm_valid                : load/store response (rdata unchanged on stores)
//  mem_req/we/mask/addr/wdata       : memory command, held until mem_valid
//  mem_rdata/mem_valid              : memory response
//  busy                             : transaction outstanding
//  err                              : timeout pulse (ARB_TIMEOUT_EN only)
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDRESS        = CMD_ADDR_W,
    parameter int unsigned DATA           = CMD_DATA_W,
    parameter int unsigned MAX_DM_BURST   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [ADDRESS-1:0] if_addr,
    output logic [DATA-1:0]    if_rdata,
    output logic               if_valid,
    input  logic               dm_req,
    input  logic               dm_we,
    input  logic [3:0]         dm_mask,
    input  logic [ADDRESS-1:0] dm_addr,
    input  logic [DATA-1:0]    dm_wdata,
    output logic [DATA-1:0]    dm_rdata,
    output logic               dm_valid,
    output logic               mem_req,
    output logic               mem_we,
    output logic [3:0]         mem_mask,
    output logic [ADDRESS-1:0] mem_addr,
    output logic [DATA-1:0]    mem_wdata,
    input  logic [DATA-1:0]    mem_rdata,
    input  logic               mem_valid,
    output logic               busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic               err
`endif
);

    localparam int unsigned BURST_W = $clog2(MAX_DM_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DM_BURST);

    arb_state_e state_q, state_d;
    mem_cmd_t   cmd_q, cmd_d;
    logic       mem_req_q, mem_req_d;
    logic [DATA-1:0] if_rdata_q, if_rdata_d;
    logic [DATA-1:0] dm_rdata_q, dm_rdata_d;
    logic       if_valid_q, if_valid_d;
    logic       dm_valid_q, dm_valid_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic       timeout;
    logic       grant;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic err_q, err_d;

    // Loaded on the grant edge so the first busy cycle sees TIMEOUT_CYCLES-1 and the
    // TIMEOUT_CYCLES-th busy cycle sees zero.
    mem_arb_watchdog #(
        .WIDTH (WD_W)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .load       (grant),
        .load_value (WD_W'(TIMEOUT_CYCLES - 1)),
        .enable     (busy),
        .expire     (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        mem_req_d  = mem_req_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
        burst_d    = burst_q;
        grant      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (dm_req && !(if_req && (burst_q == BURST_MAX))) begin
                    state_d    = ARB_DM;
                    mem_req_d  = 1'b1;
                    grant      = 1'b1;
                    cmd_d.we    = dm_we;
                    cmd_d.mask  = dm_mask;
                    cmd_d.addr  = dm_addr;
                    cmd_d.wdata = dm_wdata;
                    // Only DM grants that overtake a waiting fetch count toward the bound.
                    if (!if_req) begin
                        burst_d = '0;
                    end else if (burst_q != BURST_MAX) begin
                        burst_d = burst_q + 1'b1;
                    end
                end else if (if_req) begin
                    state_d   = ARB_IF;
                    mem_req_d = 1'b1;
                    grant     = 1'b1;
                    cmd_d     = fetch_cmd(if_addr);
                    burst_d   = '0;
                end
            end
            ARB_IF, ARB_DM: begin
                if (mem_valid) begin
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
                    if (state_q == ARB_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        dm_valid_d = 1'b1;
                        if (!cmd_q.we) begin
                            dm_rdata_d = mem_rdata;
                        end
                    end
                end else if (timeout) begin
                    // Abandon the access: complete to the requester with zero data.
                    state_d   = ARB_IDLE;
                    mem_req_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
                    err_d     = 1'b1;
`endif
                    if (state_q == ARB_IF) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = '0;
                    end else begin
                        dm_valid_d = 1'b1;
                        dm_rdata_d = '0;
                    end
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            cmd_q      <= '0;
            mem_req_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            burst_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            mem_req_q  <= mem_req_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
            burst_q    <= burst_d;
`ifdef ARB_TIMEOUT_EN
            err_q      <= err_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = cmd_q.we;
    assign mem_mask  = cmd_q.mask;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign busy      = (state_q != ARB_IDLE);
`ifdef ARB_TIMEOUT_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int unsigned MAX_B  = 4;
    localparam int unsigned TO_CYC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_mask;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        busy;
`ifdef ARB_TIMEOUT_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: outstanding requests, burst bound, last returned data.
    bit          if_pend;
    bit          dm_pend;
    logic [31:0] m_if_addr;
    logic        m_dm_we;
    logic [3:0]  m_dm_mask;
    logic [31:0] m_dm_addr;
    logic [31:0] m_dm_wdata;
    int          burst_m;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;

    mem_port_arbiter #(
        .ADDRESS        (32),
        .DATA           (32),
        .MAX_DM_BURST   (MAX_B),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_mask   (dm_mask),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_mask  (mem_mask),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_valid (mem_valid),
        .busy      (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic raise_if(input logic [31:0] addr);
        if_pend   = 1'b1;
        m_if_addr = addr;
        if_req    = 1'b1;
        if_addr   = addr;
    endtask

    task automatic raise_dm(input logic we, input logic [3:0] mask, input logic [31:0] addr,
                            input logic [31:0] wdata);
        dm_pend    = 1'b1;
        m_dm_we    = we;
        m_dm_mask  = mask;
        m_dm_addr  = addr;
        m_dm_wdata = wdata;
        dm_req     = 1'b1;
        dm_we      = we;
        dm_mask    = mask;
        dm_addr    = addr;
        dm_wdata   = wdata;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        if_req    = 1'b0;
        dm_req    = 1'b0;
        mem_valid = 1'b0;
        step();
        step();
        rst          = 1'b1;
        if_pend      = 1'b0;
        dm_pend      = 1'b0;
        burst_m      = 0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
    endtask

    // One arbitrated transaction: called at a falling edge with the arbiter idle and the
    // requests already driven. Memory answers lat cycles after mem_req is first seen.
    task automatic do_txn(input int lat, input logic [31:0] data, input bit drop_mid);
        bit          pick_dm;
        logic        e_we;
        logic [3:0]  e_mask;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        int          n;
        pick_dm = dm_pend && !(if_pend && burst_m == MAX_B);
        if (pick_dm) begin
            e_we    = m_dm_we;
            e_mask  = m_dm_mask;
            e_addr  = m_dm_addr;
            e_wdata = m_dm_wdata;
            burst_m = if_pend ? ((burst_m < MAX_B) ? burst_m + 1 : MAX_B) : 0;
        end else begin
            e_we    = 1'b0;
            e_mask  = 4'hF;
            e_addr  = m_if_addr;
            e_wdata = '0;
            burst_m = 0;
        end
        n = 0;
        do begin
            step();
            n++;
        end while (mem_req !== 1'b1 && n < 8);
        chk32("grant_latency", n, 1);
        chk1("grant_if_valid_low", if_valid, 1'b0);
        chk1("grant_dm_valid_low", dm_valid, 1'b0);
        chk1("grant_busy", busy, 1'b1);
        chk1("cmd_we", mem_we, e_we);
        chk32("cmd_mask", 32'(mem_mask), 32'(e_mask));
        chk32("cmd_addr", mem_addr, e_addr);
        chk32("cmd_wdata", mem_wdata, e_wdata);
        if (drop_mid) begin
            if (pick_dm) dm_req = 1'b0;
            else         if_req = 1'b0;
        end
        repeat (lat) begin
            step();
            chk1("hold_req", mem_req, 1'b1);
            chk32("hold_addr", mem_addr, e_addr);
        end
        mem_valid = 1'b1;
        mem_rdata = data;
        step();
        mem_valid = 1'b0;
        mem_rdata = $urandom;
        if (!pick_dm)  exp_if_rdata = data;
        else if (!e_we) exp_dm_rdata = data;
        chk1("rsp_if_valid", if_valid, !pick_dm);
        chk1("rsp_dm_valid", dm_valid, pick_dm);
        chk32("rsp_if_rdata", if_rdata, exp_if_rdata);
        chk32("rsp_dm_rdata", dm_rdata, exp_dm_rdata);
        chk1("rsp_mem_req_low", mem_req, 1'b0);
        chk1("rsp_busy_low", busy, 1'b0);
`ifdef ARB_TIMEOUT_EN
        chk1("rsp_err_low", err, 1'b0);
`endif
        if (pick_dm) begin
            dm_pend = 1'b0;
            dm_req  = 1'b0;
        end else begin
            if_pend = 1'b0;
            if_req  = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        if_addr = '0; dm_we = 1'b0; dm_mask = '0; dm_addr = '0; dm_wdata = '0;
        mem_rdata = '0;
        do_reset();

        // Reset state
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_mask", 32'(mem_mask), 32'h0);
        chk32("rst_mem_addr", mem_addr, 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_if_valid", if_valid, 1'b0);
        chk1("rst_dm_valid", dm_valid, 1'b0);
        chk32("rst_if_rdata", if_rdata, 32'h0);
        chk32("rst_dm_rdata", dm_rdata, 32'h0);
        chk1("rst_busy", busy, 1'b0);
`ifdef ARB_TIMEOUT_EN
        chk1("rst_err", err, 1'b0);
`endif

        // Fetch only, memory answers two cycles after mem_req
        raise_if(32'h10);
        do_txn(2, 32'h0050_0093, 1'b0);
        chk32("t1_if_rdata", if_rdata, 32'h0050_0093);

        // Simultaneous requests: DM first, then IF after one idle cycle
        raise_if(32'h10);
        raise_dm(1'b0, 4'hF, 32'h200, 32'h0);
        do_txn(1, 32'h1111_2222, 1'b0);
        chk32("t2_dm_rdata", dm_rdata, 32'h1111_2222);
        do_txn(0, 32'h3333_4444, 1'b0);
        chk32("t2_if_rdata", if_rdata, 32'h3333_4444);

        // DM held continuously with a waiting fetch: 4 DM, 1 IF, then DM
        raise_if(32'h40);
        for (int k = 0; k < 6; k++) begin
            if (!dm_pend) raise_dm(1'b0, 4'hF, 32'h1000 + 32'(k) * 4, 32'h0);
            do_txn(1, 32'hA000_0000 + 32'(k), 1'b0);
        end
        chk32("t3_if_rdata", if_rdata, 32'hA000_0004);
        chk32("t3_dm_rdata", dm_rdata, 32'hA000_0005);

        // Store leaves dm_rdata untouched
        raise_dm(1'b1, 4'b0011, 32'h204, 32'hABCD);
        do_txn(1, 32'hFFFF_FFFF, 1'b0);
        chk32("t4_dm_rdata_kept", dm_rdata, 32'hA000_0005);

        // mem_valid while idle is ignored
        mem_valid = 1'b1;
        mem_rdata = 32'h5555_5555;
        step();
        mem_valid = 1'b0;
        chk1("idle_mv_if_valid", if_valid, 1'b0);
        chk1("idle_mv_dm_valid", dm_valid, 1'b0);
        chk32("idle_mv_if_rdata", if_rdata, exp_if_rdata);
        chk1("idle_mv_busy", busy, 1'b0);

        // Reset while DM awaits mem_valid; late mem_valid ignored
        raise_dm(1'b0, 4'hF, 32'h300, 32'h0);
        step();
        chk1("t5_granted", mem_req, 1'b1);
        step();
        rst = 1'b0;
        dm_req = 1'b0;
        dm_pend = 1'b0;
        step();
        chk1("t5_mem_req", mem_req, 1'b0);
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_dm_valid", dm_valid, 1'b0);
        rst = 1'b1;
        burst_m = 0;
        exp_if_rdata = '0;
        exp_dm_rdata = '0;
        mem_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_valid = 1'b0;
        chk1("t5_late_dm_valid", dm_valid, 1'b0);
        chk1("t5_late_if_valid", if_valid, 1'b0);
        chk32("t5_late_dm_rdata", dm_rdata, 32'h0);
        chk1("t5_late_busy", busy, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Memory never answers a fetch
        raise_if(32'h80);
        step();
        chk1("t6_granted", mem_req, 1'b1);
        for (int k = 0; k < int'(TO_CYC) - 1; k++) begin
            step();
            chk1("t6_wait_err", err, 1'b0);
            chk1("t6_wait_req", mem_req, 1'b1);
        end
        step();
        chk1("t6_err", err, 1'b1);
        chk1("t6_if_valid", if_valid, 1'b1);
        chk32("t6_if_rdata", if_rdata, 32'h0);
        chk1("t6_busy", busy, 1'b0);
        chk1("t6_mem_req", mem_req, 1'b0);
        if_req = 1'b0;
        if_pend = 1'b0;
        burst_m = 0;
        exp_if_rdata = '0;
        step();
        chk1("t6_err_pulse", err, 1'b0);
        chk1("t6_valid_pulse", if_valid, 1'b0);
`endif

        // Random traffic against the model
        for (int it = 0; it < 200; it++) begin
            if (!if_pend && $urandom_range(0, 2) != 0) raise_if($urandom);
            if (!dm_pend && $urandom_range(0, 2) != 0)
                raise_dm(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom);
            if (!if_pend && !dm_pend) begin
                step();
                chk1("rnd_idle_req", mem_req, 1'b0);
                chk1("rnd_idle_busy", busy, 1'b0);
            end else begin
                do_txn($urandom_range(0, 3), $urandom, $urandom_range(0, 4) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
